// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data cache memory arbiter.
package mem_arb_pkg;

  // State encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  // Owner / last-grant codes
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    StIdle    = IDLE,
    StGrantI  = GRANT_I,
    StGrantD  = GRANT_D,
    StRelease = RELEASE
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side not granted last.
module rr_arb2 (
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_i,
  output logic gnt_d
);
  import mem_arb_pkg::*;

  // Pick at most one grantee from the current requests
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (req_i && req_d) begin
      gnt_d = (last_grant == OWN_I);
      gnt_i = (last_grant == OWN_D);
    end else begin
      gnt_i = req_i;
      gnt_d = req_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory block port between the I-cache and the D-cache.
// Memory strobes, address and write data are registered copies of the granted request;
// returned blocks land in per-cache READDATA registers.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDRESS,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT
);
  import mem_arb_pkg::*;

  state_e state_q;
  logic   owner_q;
  logic   last_grant_q;
  // High during the first grant cycle, when M_BUSYWAIT does not yet reflect our strobe
  logic   first_q;

  logic req_i;
  logic req_d;
  logic gnt_i;
  logic gnt_d;
  logic done;

  assign req_i = I_READ;
  assign req_d = D_READ | D_WRITE;
  assign done  = ~first_q & ~M_BUSYWAIT;

  rr_arb2 u_rr_arb2 (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d)
  );

  // Stall each cache while it requests, except in the RELEASE cycle of its own transaction
  always_comb begin
    I_BUSYWAIT = 1'b0;
    D_BUSYWAIT = 1'b0;
    if (!RESET) begin
      I_BUSYWAIT = req_i & ~((state_q == StRelease) && (owner_q == OWN_I));
      D_BUSYWAIT = req_d & ~((state_q == StRelease) && (owner_q == OWN_D));
    end
  end

  // Arbitration FSM with registered memory strobes and readdata capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      first_q      <= 1'b0;
      M_READ       <= 1'b0;
      M_WRITE      <= 1'b0;
      M_ADDRESS    <= '0;
      M_WRITEDATA  <= '0;
      I_READDATA   <= '0;
      D_READDATA   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_d) begin
            state_q      <= StGrantD;
            owner_q      <= OWN_D;
            last_grant_q <= OWN_D;
            first_q      <= 1'b1;
            M_ADDRESS    <= D_ADDRESS;
            M_WRITEDATA  <= D_WRITEDATA;
            // Read and write together is treated as a write
            M_WRITE      <= D_WRITE;
            M_READ       <= ~D_WRITE;
          end else if (gnt_i) begin
            state_q      <= StGrantI;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            first_q      <= 1'b1;
            M_ADDRESS    <= I_ADDRESS;
            M_WRITE      <= 1'b0;
            M_READ       <= 1'b1;
          end
        end
        StGrantI, StGrantD: begin
          first_q <= 1'b0;
          // Requests dropped mid-grant do not abort; the access always runs to completion
          if (done) begin
            M_READ  <= 1'b0;
            M_WRITE <= 1'b0;
            state_q <= StRelease;
            if (M_READ) begin
              if (state_q == StGrantD) begin
                D_READDATA <= M_READDATA;
              end else begin
                I_READDATA <= M_READDATA;
              end
            end
          end
        end
        StRelease: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_mem_arbiter;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 128;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_READ;
  logic [AW-1:0] I_ADDRESS;
  logic [DW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ;
  logic          D_WRITE;
  logic [AW-1:0] D_ADDRESS;
  logic [DW-1:0] D_WRITEDATA;
  logic [DW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          M_READ;
  logic          M_WRITE;
  logic [AW-1:0] M_ADDRESS;
  logic [DW-1:0] M_WRITEDATA;
  logic [DW-1:0] M_READDATA;
  logic          M_BUSYWAIT;

  mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .I_READ      (I_READ),
    .I_ADDRESS   (I_ADDRESS),
    .I_READDATA  (I_READDATA),
    .I_BUSYWAIT  (I_BUSYWAIT),
    .D_READ      (D_READ),
    .D_WRITE     (D_WRITE),
    .D_ADDRESS   (D_ADDRESS),
    .D_WRITEDATA (D_WRITEDATA),
    .D_READDATA  (D_READDATA),
    .D_BUSYWAIT  (D_BUSYWAIT),
    .M_READ      (M_READ),
    .M_WRITE     (M_WRITE),
    .M_ADDRESS   (M_ADDRESS),
    .M_WRITEDATA (M_WRITEDATA),
    .M_READDATA  (M_READDATA),
    .M_BUSYWAIT  (M_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: who was served last, and what each cache should hold
  bit            last_d_m;
  logic [DW-1:0] exp_i_rd;
  logic [DW-1:0] exp_d_rd;

  function automatic logic [DW-1:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_addrs();
    I_ADDRESS   = AW'($urandom());
    D_ADDRESS   = I_ADDRESS ^ AW'($urandom_range(1, 63));
    D_WRITEDATA = rand_blk();
  endtask

  // Runs one transaction starting in an IDLE cycle with requests already driven.
  // Memory is busy for k grant cycles (the first grant cycle is random and must be ignored).
  // drop_c>0 withdraws the grantee's request in that grant cycle. Returns in the next IDLE cycle.
  task automatic run_grant(input int k, input int drop_c, input bit scramble,
                           input logic [DW-1:0] rd);
    bit            ri;
    bit            rq_d;
    bit            gd;
    bit            wr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    ri   = I_READ;
    rq_d = D_READ | D_WRITE;
    gd   = rq_d && (!ri || !last_d_m);
    wr   = gd && D_WRITE;
    ea   = gd ? D_ADDRESS : I_ADDRESS;
    ewd  = D_WRITEDATA;

    @(negedge CLK);
    n_vec++;
    if ({M_READ, M_WRITE} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_strobes: got %b want 00", {M_READ, M_WRITE});
    end
    n_vec++;
    if ({I_BUSYWAIT, D_BUSYWAIT} !== {ri, rq_d}) begin
      n_err++;
      $display("FAIL idle_busywait: got %b want %b", {I_BUSYWAIT, D_BUSYWAIT}, {ri, rq_d});
    end
    step();
    last_d_m = gd;

    for (int c = 1; c <= k + 1; c++) begin
      M_BUSYWAIT = (c == 1) ? 1'($urandom() % 2) : (c <= k);
      M_READDATA = (c == k + 1) ? rd : rand_blk();
      if (c == drop_c) begin
        if (gd) begin
          D_READ  = 1'b0;
          D_WRITE = 1'b0;
        end else begin
          I_READ = 1'b0;
        end
      end
      if (scramble && c == 2) rand_addrs();
      @(negedge CLK);
      n_vec++;
      if ({M_READ, M_WRITE} !== {~wr, wr}) begin
        n_err++;
        $display("FAIL grant_strobes c=%0d: got %b want %b", c, {M_READ, M_WRITE}, {~wr, wr});
      end
      n_vec++;
      if (M_ADDRESS !== ea) begin
        n_err++;
        $display("FAIL grant_addr c=%0d: got %h want %h", c, M_ADDRESS, ea);
      end
      if (wr) begin
        n_vec++;
        if (M_WRITEDATA !== ewd) begin
          n_err++;
          $display("FAIL grant_wdata c=%0d: got %h want %h", c, M_WRITEDATA, ewd);
        end
      end
      n_vec++;
      if ({I_BUSYWAIT, D_BUSYWAIT} !== {I_READ, D_READ | D_WRITE}) begin
        n_err++;
        $display("FAIL grant_busywait c=%0d: got %b want %b", c, {I_BUSYWAIT, D_BUSYWAIT},
                 {I_READ, D_READ | D_WRITE});
      end
      step();
    end

    if (!wr) begin
      if (gd) exp_d_rd = rd;
      else exp_i_rd = rd;
    end
    M_BUSYWAIT = 1'($urandom() % 2);
    M_READDATA = rand_blk();
    @(negedge CLK);
    n_vec++;
    if ({M_READ, M_WRITE} !== 2'b00) begin
      n_err++;
      $display("FAIL release_strobes: got %b want 00", {M_READ, M_WRITE});
    end
    n_vec++;
    if (I_READDATA !== exp_i_rd) begin
      n_err++;
      $display("FAIL i_readdata: got %h want %h", I_READDATA, exp_i_rd);
    end
    n_vec++;
    if (D_READDATA !== exp_d_rd) begin
      n_err++;
      $display("FAIL d_readdata: got %h want %h", D_READDATA, exp_d_rd);
    end
    n_vec++;
    if ({I_BUSYWAIT, D_BUSYWAIT} !== {gd ? I_READ : 1'b0, gd ? 1'b0 : (D_READ | D_WRITE)}) begin
      n_err++;
      $display("FAIL release_busywait: got %b want %b", {I_BUSYWAIT, D_BUSYWAIT},
               {gd ? I_READ : 1'b0, gd ? 1'b0 : (D_READ | D_WRITE)});
    end
    step();
  endtask

  task automatic test_reset();
    RESET       = 1'b1;
    I_READ      = 1'b1;
    D_READ      = 1'b1;
    D_WRITE     = 1'b0;
    M_BUSYWAIT  = 1'b1;
    M_READDATA  = rand_blk();
    rand_addrs();
    step();
    step();
    @(negedge CLK);
    n_vec++;
    if ({M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0000", {M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT});
    end
    n_vec++;
    if ({M_ADDRESS, M_WRITEDATA, I_READDATA, D_READDATA} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got addr %h wd %h ird %h drd %h want all zero", M_ADDRESS,
               M_WRITEDATA, I_READDATA, D_READDATA);
    end
    last_d_m = 1'b0;
    exp_i_rd = '0;
    exp_d_rd = '0;
    I_READ   = 1'b0;
    D_READ   = 1'b0;
    step();
    RESET = 1'b0;
    step();
    @(negedge CLK);
    n_vec++;
    if ({M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_quiet: got %b want 0000", {M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT});
    end
    step();
  endtask

  // Both caches keep requesting: D first after reset, then strict alternation
  task automatic test_tie_alternate();
    I_READ = 1'b1;
    D_READ = 1'b1;
    for (int n = 0; n < 4; n++) begin
      rand_addrs();
      run_grant($urandom_range(1, 4), 0, 1'b0, rand_blk());
    end
    I_READ = 1'b0;
    D_READ = 1'b0;
    step();
  endtask

  task automatic test_i_read();
    I_READ    = 1'b1;
    I_ADDRESS = 6'h05;
    run_grant(3, 0, 1'b0, {16{8'hA5}});
    I_READ = 1'b0;
  endtask

  task automatic test_d_write();
    D_WRITE     = 1'b1;
    D_ADDRESS   = 6'h12;
    D_WRITEDATA = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    run_grant(2, 0, 1'b1, rand_blk());
    D_WRITE = 1'b0;
  endtask

  task automatic test_withdraw();
    I_READ    = 1'b1;
    I_ADDRESS = AW'($urandom());
    run_grant(3, 2, 1'b0, rand_blk());
    for (int n = 0; n < 2; n++) begin
      @(negedge CLK);
      n_vec++;
      if ({M_READ, M_WRITE, I_BUSYWAIT} !== 3'b000) begin
        n_err++;
        $display("FAIL withdraw_no_regrant: got %b want 000", {M_READ, M_WRITE, I_BUSYWAIT});
      end
      step();
    end
  endtask

  task automatic test_rw_both();
    D_READ  = 1'b1;
    D_WRITE = 1'b1;
    rand_addrs();
    run_grant(1, 0, 1'b0, rand_blk());
    D_READ  = 1'b0;
    D_WRITE = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    D_WRITE    = 1'b1;
    M_BUSYWAIT = 1'b1;
    rand_addrs();
    step();
    @(negedge CLK);
    n_vec++;
    if (M_WRITE !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_granted: got %b want 1", M_WRITE);
    end
    step();
    RESET  = 1'b1;
    I_READ = 1'b1;
    @(negedge CLK);
    n_vec++;
    if ({I_BUSYWAIT, D_BUSYWAIT} !== 2'b00) begin
      n_err++;
      $display("FAIL midreset_busy_now: got %b want 00", {I_BUSYWAIT, D_BUSYWAIT});
    end
    step();
    @(negedge CLK);
    n_vec++;
    if ({M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT} !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_after_edge: got %b want 0000",
               {M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT});
    end
    last_d_m = 1'b0;
    exp_i_rd = '0;
    exp_d_rd = '0;
    step();
    RESET = 1'b0;
    rand_addrs();
    run_grant(2, 0, 1'b0, rand_blk());
    D_WRITE = 1'b0;
    run_grant(1, 0, 1'b0, rand_blk());
    I_READ = 1'b0;
  endtask

  task automatic test_random();
    int r;
    int op;
    int k;
    for (int n = 0; n < 24; n++) begin
      if ($urandom() % 4 == 0) begin
        I_READ  = 1'b0;
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
        @(negedge CLK);
        n_vec++;
        if ({M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT} !== 4'b0000) begin
          n_err++;
          $display("FAIL rand_idle: got %b want 0000", {M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT});
        end
        step();
      end
      r  = $urandom_range(1, 3);
      op = $urandom_range(1, 3);
      I_READ  = r[0];
      D_READ  = r[1] & op[0];
      D_WRITE = r[1] & op[1];
      rand_addrs();
      k = $urandom_range(1, 4);
      run_grant(k, $urandom_range(0, k + 1), 1'b1, rand_blk());
    end
    I_READ  = 1'b0;
    D_READ  = 1'b0;
    D_WRITE = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_tie_alternate();
    test_i_read();
    test_d_write();
    test_withdraw();
    test_rw_both();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
